// File: rtl/traffic_fsm_if.sv
// Lamp/timebase bundle between the intersection controller and its surroundings.
// master drives tick/sensor/wr and observes lamps; slave is the controller.
interface traffic_fsm_if;
    logic tick;
    logic sensor;
    logic wr;
    logic wr_reset;
    logic main_grn;
    logic main_yel;
    logic main_red;
    logic side_grn;
    logic side_yel;
    logic side_red;
    logic walk_lamp;

    modport master (
        output tick, sensor, wr,
        input  wr_reset, main_grn, main_yel, main_red,
        input  side_grn, side_yel, side_red, walk_lamp
    );

    modport slave (
        input  tick, sensor, wr,
        output wr_reset, main_grn, main_yel, main_red,
        output side_grn, side_yel, side_red, walk_lamp
    );
endinterface

// File: rtl/traffic_fsm.sv
// Main/side street traffic light controller with walk phase, tick-timed intervals.
// Lamps are Moore outputs of the state register; wr_reset is registered; no backpressure.
module traffic_fsm #(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2
) (
    input  logic          clk,
    input  logic          reset,
    traffic_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        MG1  = 3'd0,
        MG2  = 3'd1,
        MY   = 3'd2,
        WALK = 3'd3,
        SG1  = 3'd4,
        SG2  = 3'd5,
        SY   = 3'd6
    } state_e;

    localparam logic [3:0] BASE_LAST = 4'(T_BASE - 1);
    localparam logic [3:0] EXT_LAST  = 4'(T_EXT - 1);
    localparam logic [3:0] YEL_LAST  = 4'(T_YEL - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ext_q, ext_d;
    logic       wr_reset_q, wr_reset_d;
    logic [3:0] last_cnt;
    logic       expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MG1;
            cnt_q      <= 4'd0;
            ext_q      <= 1'b0;
            wr_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ext_q      <= ext_d;
            wr_reset_q <= wr_reset_d;
        end
    end

    always_comb begin
        last_cnt   = BASE_LAST;
        state_d    = state_q;
        ext_d      = ext_q;
        cnt_d      = bus.tick ? cnt_q + 4'd1 : cnt_q;
        wr_reset_d = 1'b0;

        case (state_q)
            MG2:      last_cnt = ext_q ? EXT_LAST : BASE_LAST;
            MY, SY:   last_cnt = YEL_LAST;
            WALK, SG2: last_cnt = EXT_LAST;
            default:  last_cnt = BASE_LAST;
        endcase
        expire = bus.tick && (cnt_q == last_cnt);

        // sensor and wr only matter on the expiry cycle of the state that reads them
        case (state_q)
            MG1: if (expire) begin
                state_d = MG2;
                ext_d   = bus.sensor;
            end
            MG2:  if (expire) state_d = MY;
            MY:   if (expire) state_d = bus.wr ? WALK : SG1;
            WALK: if (expire) state_d = SG1;
            SG1:  if (expire) state_d = bus.sensor ? SG2 : SY;
            SG2:  if (expire) state_d = SY;
            SY:   if (expire) state_d = MG1;
            default: state_d = MG1;
        endcase

        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end
        wr_reset_d = (state_d == WALK) && (state_q != WALK);
    end

    always_comb begin
        bus.main_grn  = 1'b0;
        bus.main_yel  = 1'b0;
        bus.main_red  = 1'b0;
        bus.side_grn  = 1'b0;
        bus.side_yel  = 1'b0;
        bus.side_red  = 1'b0;
        bus.walk_lamp = 1'b0;
        case (state_q)
            MY: begin
                bus.main_yel = 1'b1;
                bus.side_red = 1'b1;
            end
            WALK: begin
                bus.main_red  = 1'b1;
                bus.side_red  = 1'b1;
                bus.walk_lamp = 1'b1;
            end
            SG1, SG2: begin
                bus.main_red = 1'b1;
                bus.side_grn = 1'b1;
            end
            SY: begin
                bus.main_red = 1'b1;
                bus.side_yel = 1'b1;
            end
            default: begin
                bus.main_grn = 1'b1;
                bus.side_red = 1'b1;
            end
        endcase
    end

    assign bus.wr_reset = wr_reset_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench for traffic_fsm: phase/countdown reference model plus scenario tasks.
module tb_traffic_fsm;
    localparam int T_BASE = 6;
    localparam int T_EXT  = 3;
    localparam int T_YEL  = 2;

    localparam int PH_MG1 = 0, PH_MG2 = 1, PH_MY = 2, PH_WALK = 3;
    localparam int PH_SG1 = 4, PH_SG2 = 5, PH_SY = 6;

    localparam logic [6:0] L_MG   = 7'b1000010;
    localparam logic [6:0] L_MY   = 7'b0100010;
    localparam logic [6:0] L_WALK = 7'b0010011;
    localparam logic [6:0] L_SG   = 7'b0011000;
    localparam logic [6:0] L_SY   = 7'b0010100;

    logic clk = 1'b0;
    logic reset;
    traffic_fsm_if bus ();

    traffic_fsm #(.T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] dut_lamps;
    assign dut_lamps = {bus.main_grn, bus.main_yel, bus.main_red,
                        bus.side_grn, bus.side_yel, bus.side_red, bus.walk_lamp};

    // Reference: current phase and ticks remaining before it ends.
    int m_phase;
    int m_left;
    int m_mg2_len;
    bit m_wrr;

    task automatic model_step(input bit t, input bit s, input bit w, input bit r);
        if (r) begin
            m_phase = PH_MG1; m_left = T_BASE; m_mg2_len = T_BASE; m_wrr = 1'b0;
            return;
        end
        m_wrr = 1'b0;
        if (!t) return;
        m_left = m_left - 1;
        if (m_left != 0) return;
        case (m_phase)
            PH_MG1: begin
                m_mg2_len = s ? T_EXT : T_BASE;
                m_phase = PH_MG2; m_left = m_mg2_len;
            end
            PH_MG2: begin m_phase = PH_MY; m_left = T_YEL; end
            PH_MY: begin
                if (w) begin m_phase = PH_WALK; m_left = T_EXT; m_wrr = 1'b1; end
                else   begin m_phase = PH_SG1;  m_left = T_BASE; end
            end
            PH_WALK: begin m_phase = PH_SG1; m_left = T_BASE; end
            PH_SG1: begin
                if (s) begin m_phase = PH_SG2; m_left = T_EXT; end
                else   begin m_phase = PH_SY;  m_left = T_YEL; end
            end
            PH_SG2: begin m_phase = PH_SY; m_left = T_YEL; end
            default: begin m_phase = PH_MG1; m_left = T_BASE; end
        endcase
    endtask

    function automatic logic [6:0] exp_lamps();
        case (m_phase)
            PH_MY:           return L_MY;
            PH_WALK:         return L_WALK;
            PH_SG1, PH_SG2:  return L_SG;
            PH_SY:           return L_SY;
            default:         return L_MG;
        endcase
    endfunction

    task automatic cyc(input bit t, input bit s, input bit w, input bit r);
        bus.tick = t; bus.sensor = s; bus.wr = w; reset = r;
        @(posedge clk);
        model_step(t, s, w, r);
        #1;
    endtask

    // Continuous lamp invariants
    bit mon_en = 1'b0;
    bit rst_seen = 1'b1;
    bit prev_mg = 1'b0;
    bit prev_sg = 1'b0;
    always @(posedge clk) rst_seen <= reset;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones({bus.main_grn, bus.main_yel, bus.main_red}) != 1 ||
                $countones({bus.side_grn, bus.side_yel, bus.side_red}) != 1) begin
                errors++;
                $display("FAIL lamp_onehot lamps=%b required one main and one side", dut_lamps);
            end
            checks++;
            if (!rst_seen && ((prev_mg && bus.side_grn) || (prev_sg && bus.main_grn))) begin
                errors++;
                $display("FAIL green_to_green lamps=%b prev_mg=%0b prev_sg=%0b required yellow between",
                         dut_lamps, prev_mg, prev_sg);
            end
            prev_mg = bus.main_grn;
            prev_sg = bus.side_grn;
        end
    end

    task automatic test_reset();
        cyc(1, 1, 1, 1);
        cyc(1, 1, 1, 1);
        mon_en = 1'b1;
        checks++;
        if (dut_lamps !== L_MG) begin
            errors++; $display("FAIL reset_lamps got=%b exp=%b", dut_lamps, L_MG);
        end
        checks++;
        if (bus.wr_reset !== 1'b0) begin
            errors++; $display("FAIL reset_wr_reset got=%b exp=0", bus.wr_reset);
        end
    endtask

    task automatic run_period(input bit s, input string name);
        int first, second, idx;
        bit prev_sy;
        first = -1; second = -1; prev_sy = 1'b0;
        cyc(1, s, 0, 1);
        for (idx = 0; idx < 60; idx++) begin
            cyc(1, s, 0, 0);
            checks++;
            if ({dut_lamps, bus.wr_reset} !== {exp_lamps(), m_wrr}) begin
                errors++;
                $display("FAIL %s_model cyc=%0d got=%b/%b exp=%b/%b", name, idx,
                         dut_lamps, bus.wr_reset, exp_lamps(), m_wrr);
            end
            if (prev_sy && bus.main_grn) begin
                if (first < 0) first = idx; else if (second < 0) second = idx;
            end
            prev_sy = bus.side_yel;
        end
        checks++;
        if (second - first != 22) begin
            errors++;
            $display("FAIL %s_period got=%0d exp=22", name, second - first);
        end
    endtask

    task automatic test_default_cycle();
        run_period(1'b0, "default");
    endtask

    task automatic test_sensor_cycle();
        run_period(1'b1, "sensor");
    endtask

    task automatic test_walk();
        int n;
        cyc(1, 0, 1, 1);
        n = 0;
        while (!bus.walk_lamp && n < 40) begin
            cyc(1, 0, 1, 0);
            n++;
        end
        checks++;
        if (!bus.walk_lamp || n != 2 * T_BASE + T_YEL) begin
            errors++; $display("FAIL walk_entry cycles=%0d exp=%0d walk=%b", n, 2 * T_BASE + T_YEL, bus.walk_lamp);
        end
        for (int k = 0; k < T_EXT; k++) begin
            checks++;
            if (dut_lamps !== L_WALK || bus.wr_reset !== (k == 0)) begin
                errors++;
                $display("FAIL walk_cycle k=%0d lamps=%b wr_reset=%b exp=%b/%0b", k, dut_lamps, bus.wr_reset, L_WALK, k == 0);
            end
            cyc(1, 0, 1, 0);
        end
        checks++;
        if (dut_lamps !== L_SG || bus.wr_reset !== 1'b0 || {dut_lamps, bus.wr_reset} !== {exp_lamps(), m_wrr}) begin
            errors++; $display("FAIL walk_exit lamps=%b wr_reset=%b exp=%b/0", dut_lamps, bus.wr_reset, L_SG);
        end
    endtask

    task automatic test_slow_tick();
        int i, n;
        cyc(0, 0, 0, 1);
        i = 0; n = 1;
        while (bus.main_grn && i < 200) begin
            cyc((i % 4) == 3, 0, 0, 0);
            i++;
            if (bus.main_grn) n++;
            checks++;
            if ({dut_lamps, bus.wr_reset} !== {exp_lamps(), m_wrr}) begin
                errors++; $display("FAIL slow_model i=%0d got=%b exp=%b", i, dut_lamps, exp_lamps());
            end
        end
        checks++;
        if (n != 2 * T_BASE * 4 || dut_lamps !== L_MY) begin
            errors++; $display("FAIL slow_green_len got=%0d exp=%0d lamps=%b", n, 2 * T_BASE * 4, dut_lamps);
        end
        for (int k = 0; k < 50; k++) begin
            cyc(0, 1'($urandom), 1'($urandom), 0);
            checks++;
            if (dut_lamps !== L_MY) begin
                errors++; $display("FAIL freeze k=%0d got=%b exp=%b", k, dut_lamps, L_MY);
            end
        end
        cyc(1, 0, 0, 0);
        checks++;
        if (dut_lamps !== exp_lamps()) begin
            errors++; $display("FAIL freeze_resume got=%b exp=%b", dut_lamps, exp_lamps());
        end
    endtask

    task automatic test_reset_in_walk();
        int n;
        cyc(1, 0, 1, 1);
        n = 0;
        while (!bus.walk_lamp && n < 40) begin
            cyc(1, 0, 1, 0);
            n++;
        end
        cyc(1, 0, 1, 0);
        checks++;
        if (dut_lamps !== L_WALK || bus.wr_reset !== 1'b0) begin
            errors++; $display("FAIL walk_second lamps=%b wr_reset=%b exp=%b/0", dut_lamps, bus.wr_reset, L_WALK);
        end
        cyc(1, 0, 1, 1);
        checks++;
        if (dut_lamps !== L_MG || bus.wr_reset !== 1'b0) begin
            errors++; $display("FAIL walk_abort lamps=%b wr_reset=%b exp=%b/0", dut_lamps, bus.wr_reset, L_MG);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 0, 0);
            checks++;
            if (bus.wr_reset !== 1'b0 || bus.walk_lamp !== 1'b0) begin
                errors++; $display("FAIL walk_abort_after k=%0d wr_reset=%b walk=%b exp=0/0", k, bus.wr_reset, bus.walk_lamp);
            end
        end
    endtask

    task automatic test_wr_outside_expiry();
        bit saw_walk;
        saw_walk = 1'b0;
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 30; k++) begin
            // wr only on the non-expiry MY cycle, never at expiry
            cyc(1, 0, (m_phase == PH_MY) && (m_left == T_YEL), 0);
            if (bus.walk_lamp) saw_walk = 1'b1;
        end
        checks++;
        if (saw_walk) begin
            errors++; $display("FAIL wr_outside_expiry walk=1 exp=0");
        end
    endtask

    task automatic test_random();
        bit t, s, w, r;
        for (int k = 0; k < 3000; k++) begin
            t = ($urandom_range(0, 2) != 0);
            s = 1'($urandom);
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(t, s, w, r);
            checks++;
            if ({dut_lamps, bus.wr_reset} !== {exp_lamps(), m_wrr}) begin
                errors++;
                $display("FAIL random_model k=%0d got=%b/%b exp=%b/%b", k, dut_lamps, bus.wr_reset, exp_lamps(), m_wrr);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 1'b0; bus.sensor = 1'b0; bus.wr = 1'b0;
        test_reset();
        test_default_cycle();
        test_sensor_cycle();
        test_walk();
        test_slow_tick();
        test_reset_in_walk();
        test_wr_outside_expiry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 The block SHALL expose parameter T_BASE, default 6, base green interval in ticks (legal 1..15).
REQ-002 The block SHALL expose parameter T_EXT, default 3, extended-green and walk interval in ticks (legal 1..15).
REQ-003 The block SHALL expose parameter T_YEL, default 2, yellow interval in ticks (legal 1..15).
REQ-004 The block SHALL have one clock, clk, input, 1 bit, with all state updated on its rising edge.
REQ-005 The block SHALL have reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have tick, input, 1 bit, one-cycle timebase enable from the upstream divider.
REQ-007 The block SHALL have sensor, input, 1 bit, side-street vehicle present (already synchronised).
REQ-008 The block SHALL have wr, input, 1 bit, latched walk request from the walk register.
REQ-009 The block SHALL have wr_reset, output, 1 bit, clear pulse back to the walk register.
REQ-010 The block SHALL have main_grn, main_yel, main_red, side_grn, side_yel, side_red, and walk_lamp, each an output, 1 bit, lamp drive.

Function
REQ-011 The block SHALL implement states MG1, MG2, MY, WALK, SG1, SG2, and SY in a registered state variable.
REQ-012 The block SHALL keep a 4-bit tick counter, cleared on every state change, that increments only when tick=1.
REQ-013 A state SHALL expire on the cycle where tick=1 and the counter equals its interval minus 1; the transition takes effect on that edge.
REQ-014 The state intervals SHALL be: MG1=T_BASE; MG2=T_EXT if sensor=1 on the MG1 expiry cycle, else T_BASE; MY=T_YEL; WALK=T_EXT; SG1=T_BASE; SG2=T_EXT; SY=T_YEL.
REQ-015 The MG2 interval choice SHALL be captured in a 1-bit register at MG1 expiry and held for the whole of MG2.
REQ-016 The state sequence SHALL be MG1->MG2->MY, then MY->WALK if wr=1 on the MY expiry cycle, else MY->SG1.
REQ-017 The state sequence SHALL continue WALK->SG1, then SG1->SG2 if sensor=1 on the SG1 expiry cycle, else SG1->SY.
REQ-018 The state sequence SHALL close with SG2->SY and SY->MG1.
REQ-019 Lamps SHALL decode from the state register only (Moore) as follows:
- MG1/MG2: main_grn+side_red.
- MY: main_yel+side_red.
- WALK: main_red+side_red+walk_lamp.
- SG1/SG2: main_red+side_grn.
- SY: main_red+side_yel.
- Exactly one main lamp and one side lamp SHALL be high at all times.
REQ-020 wr_reset SHALL be a registered output, high for exactly the first clock cycle spent in WALK and low otherwise.
REQ-021 A wr asserting outside the MY expiry cycle SHALL have no effect until the next MY expiry; wr SHALL be sampled at no other time.
REQ-022 sensor and wr changing in the same cycle as a non-expiry tick SHALL NOT alter state or counter.
REQ-023 With tick=0 the state and counter SHALL hold indefinitely.
REQ-024 If tick=1 and reset=1 in the same cycle, reset SHALL take priority.
REQ-025 Unreachable state encodings SHALL recover to MG1 with the counter cleared on the next edge.

Reset
REQ-026 On reset=1 at a rising edge, the block SHALL set state=MG1, counter=0, and the MG2-interval register=T_BASE.
REQ-027 On reset=1, wr_reset SHALL be 0.
REQ-028 On reset=1, the lamp outputs SHALL be main_grn=1 and side_red=1, with all other lamps and walk_lamp=0.
REQ-029 Reset asserted mid-interval, including during WALK, SHALL abort immediately with no wr_reset pulse generated.

Verification
REQ-030 Scenario: defaults, tick=1 every cycle, sensor=0, wr=0 -> states last MG1 6, MG2 6, MY 2, SG1 6, SY 2 cycles; period 22.
REQ-031 Scenario: sensor=1 constantly, wr=0 -> states last MG1 6, MG2 3, MY 2, SG1 6, SG2 3, SY 2 cycles; period 22.
REQ-032 Scenario: wr=1 held from reset release -> WALK entered after MY and lasts 3 cycles with walk_lamp=1 and all other lamps red.
REQ-033 Scenario: wr=1 held from reset release -> wr_reset=1 for the first WALK cycle only, then SG1.
REQ-034 Scenario: tick every 4th cycle, sensor=0 -> MG1 lasts 24 cycles; with tick held 0 for 50 cycles in MY, the state is frozen.
REQ-035 Scenario: reset=1 for one cycle during the second WALK cycle -> next cycle MG1, main_grn=1, side_red=1, walk_lamp=0, and wr_reset=0 throughout.
REQ-036 The bench SHALL continuously check the one-main/one-side lamp invariant and that green never directly follows the opposite green without a yellow.
